// File: rtl/conv5x5_ctrl_if.sv
// Host/datapath-facing bundle of the CONV5x5 sequencer: start handshake, image
// address with MAC tap strobes, and result-memory read/write strobes.
interface conv5x5_ctrl_if #(
  parameter int AW = 12,
  parameter int TW = 5
);
  logic          ready;
  logic          busy;
  logic [AW-1:0] iaddr;
  logic          tap_vld;
  logic          tap_pad;
  logic [TW-1:0] tap_idx;
  logic          tap_first;
  logic          tap_last;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic          pool_vld;
  logic          pool_first;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic          csel;

  modport slave (
    input  ready,
    output busy, iaddr, tap_vld, tap_pad, tap_idx, tap_first, tap_last,
           crd, caddr_rd, pool_vld, pool_first, cwr, caddr_wr, csel
  );

  modport master (
    output ready,
    input  busy, iaddr, tap_vld, tap_pad, tap_idx, tap_first, tap_last,
           crd, caddr_rd, pool_vld, pool_first, cwr, caddr_wr, csel
  );
endinterface

// File: rtl/conv5x5_ctrl.sv
// CONV5x5 sequencer: zero-padded KSZxKSZ window scan with layer-0 writes, then a
// 2x2 max-pool pass into layer-1. All outputs are registered from next-state values.
module conv5x5_ctrl #(
  parameter int IW  = 64,
  parameter int IH  = 64,
  parameter int KSZ = 5
) (
  input  logic          clk,
  input  logic          reset,
  conv5x5_ctrl_if.slave bus
);
  localparam int CW  = $clog2(IW);
  localparam int RW  = $clog2(IH);
  localparam int AW  = CW + RW;
  localparam int PAD = (KSZ - 1) / 2;
  localparam int NT  = KSZ * KSZ;
  localparam int TW  = $clog2(NT);
  localparam int KW  = $clog2(KSZ);

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_L0WR, S_POOL, S_L1WR, S_DONE} state_t;

  state_t          r_state, w_state_n;
  logic [RW-1:0]   r_row, w_row_n;
  logic [CW-1:0]   r_col, w_col_n;
  logic [TW-1:0]   r_tap, w_tap_n;
  logic [KW-1:0]   r_ky, w_ky_n, r_kx, w_kx_n;
  logic [RW-2:0]   r_prow, w_prow_n;
  logic [CW-2:0]   r_pcol, w_pcol_n;
  logic [1:0]      r_q, w_q_n;

  logic            r_busy, w_busy;
  logic [AW-1:0]   r_iaddr, w_iaddr;
  logic            r_tap_vld, w_tap_vld, r_tap_pad, w_tap_pad;
  logic [TW-1:0]   r_tap_idx, w_tap_idx;
  logic            r_tap_first, w_tap_first, r_tap_last, w_tap_last;
  logic            r_crd, w_crd, r_pool_vld, w_pool_vld, r_pool_first, w_pool_first;
  logic [AW-1:0]   r_caddr_rd, w_caddr_rd, r_caddr_wr, w_caddr_wr;
  logic            r_cwr, w_cwr, r_csel, w_csel;
  logic [RW+1:0]   w_y;
  logic [CW+1:0]   w_x;

  always_comb begin
    w_state_n = r_state;
    w_row_n   = r_row;
    w_col_n   = r_col;
    w_tap_n   = r_tap;
    w_ky_n    = r_ky;
    w_kx_n    = r_kx;
    w_prow_n  = r_prow;
    w_pcol_n  = r_pcol;
    w_q_n     = r_q;
    case (r_state)
      S_IDLE: if (bus.ready) begin
        w_state_n = S_CONV;
        w_row_n   = '0;
        w_col_n   = '0;
        w_tap_n   = '0;
        w_ky_n    = '0;
        w_kx_n    = '0;
      end
      S_CONV: if (r_tap == TW'(NT - 1)) begin
        w_state_n = S_L0WR;
      end else begin
        w_tap_n = r_tap + 1'b1;
        if (r_kx == KW'(KSZ - 1)) begin
          w_kx_n = '0;
          w_ky_n = r_ky + 1'b1;
        end else begin
          w_kx_n = r_kx + 1'b1;
        end
      end
      S_L0WR: begin
        w_tap_n   = '0;
        w_ky_n    = '0;
        w_kx_n    = '0;
        w_state_n = S_CONV;
        if (&r_col) begin
          w_col_n = '0;
          if (&r_row) begin
            w_state_n = S_POOL;
            w_row_n   = '0;
            w_prow_n  = '0;
            w_pcol_n  = '0;
            w_q_n     = '0;
          end else begin
            w_row_n = r_row + 1'b1;
          end
        end else begin
          w_col_n = r_col + 1'b1;
        end
      end
      S_POOL: begin
        w_q_n = r_q + 1'b1;
        if (r_q == 2'd3) w_state_n = S_L1WR;
      end
      S_L1WR: begin
        w_state_n = S_POOL;
        if (&r_pcol) begin
          w_pcol_n = '0;
          if (&r_prow) begin
            w_state_n = S_DONE;
            w_prow_n  = '0;
          end else begin
            w_prow_n = r_prow + 1'b1;
          end
        end else begin
          w_pcol_n = r_pcol + 1'b1;
        end
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // Window coordinates wrap modulo 4*IH / 4*IW, so any set bit above the image
  // range means the tap is either negative or past the far edge.
  assign w_y = {2'b00, w_row_n} + (RW + 2)'(w_ky_n) - (RW + 2)'(PAD);
  assign w_x = {2'b00, w_col_n} + (CW + 2)'(w_kx_n) - (CW + 2)'(PAD);

  always_comb begin
    w_busy       = 1'b0;
    w_iaddr      = '0;
    w_tap_vld    = 1'b0;
    w_tap_pad    = 1'b0;
    w_tap_idx    = '0;
    w_tap_first  = 1'b0;
    w_tap_last   = 1'b0;
    w_crd        = 1'b0;
    w_caddr_rd   = '0;
    w_pool_vld   = 1'b0;
    w_pool_first = 1'b0;
    w_cwr        = 1'b0;
    w_caddr_wr   = '0;
    w_csel       = 1'b0;
    case (w_state_n)
      S_CONV: begin
        w_busy      = 1'b1;
        w_tap_vld   = 1'b1;
        w_tap_idx   = w_tap_n;
        w_tap_first = (w_tap_n == '0);
        w_tap_last  = (w_tap_n == TW'(NT - 1));
        if ((|w_y[RW+1:RW]) || (|w_x[CW+1:CW])) w_tap_pad = 1'b1;
        else                                    w_iaddr   = {w_y[RW-1:0], w_x[CW-1:0]};
      end
      S_L0WR: begin
        w_busy     = 1'b1;
        w_cwr      = 1'b1;
        w_caddr_wr = {w_row_n, w_col_n};
      end
      S_POOL: begin
        w_busy       = 1'b1;
        w_crd        = 1'b1;
        w_pool_vld   = 1'b1;
        w_pool_first = (w_q_n == 2'd0);
        w_caddr_rd   = {w_prow_n, w_q_n[1], w_pcol_n, w_q_n[0]};
      end
      S_L1WR: begin
        w_busy     = 1'b1;
        w_cwr      = 1'b1;
        w_csel     = 1'b1;
        w_caddr_wr = {2'b00, w_prow_n, w_pcol_n};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_tap        <= '0;
      r_ky         <= '0;
      r_kx         <= '0;
      r_prow       <= '0;
      r_pcol       <= '0;
      r_q          <= '0;
      r_busy       <= 1'b0;
      r_iaddr      <= '0;
      r_tap_vld    <= 1'b0;
      r_tap_pad    <= 1'b0;
      r_tap_idx    <= '0;
      r_tap_first  <= 1'b0;
      r_tap_last   <= 1'b0;
      r_crd        <= 1'b0;
      r_caddr_rd   <= '0;
      r_pool_vld   <= 1'b0;
      r_pool_first <= 1'b0;
      r_cwr        <= 1'b0;
      r_caddr_wr   <= '0;
      r_csel       <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_row        <= w_row_n;
      r_col        <= w_col_n;
      r_tap        <= w_tap_n;
      r_ky         <= w_ky_n;
      r_kx         <= w_kx_n;
      r_prow       <= w_prow_n;
      r_pcol       <= w_pcol_n;
      r_q          <= w_q_n;
      r_busy       <= w_busy;
      r_iaddr      <= w_iaddr;
      r_tap_vld    <= w_tap_vld;
      r_tap_pad    <= w_tap_pad;
      r_tap_idx    <= w_tap_idx;
      r_tap_first  <= w_tap_first;
      r_tap_last   <= w_tap_last;
      r_crd        <= w_crd;
      r_caddr_rd   <= w_caddr_rd;
      r_pool_vld   <= w_pool_vld;
      r_pool_first <= w_pool_first;
      r_cwr        <= w_cwr;
      r_caddr_wr   <= w_caddr_wr;
      r_csel       <= w_csel;
    end
  end

  assign bus.busy       = r_busy;
  assign bus.iaddr      = r_iaddr;
  assign bus.tap_vld    = r_tap_vld;
  assign bus.tap_pad    = r_tap_pad;
  assign bus.tap_idx    = r_tap_idx;
  assign bus.tap_first  = r_tap_first;
  assign bus.tap_last   = r_tap_last;
  assign bus.crd        = r_crd;
  assign bus.caddr_rd   = r_caddr_rd;
  assign bus.pool_vld   = r_pool_vld;
  assign bus.pool_first = r_pool_first;
  assign bus.cwr        = r_cwr;
  assign bus.caddr_wr   = r_caddr_wr;
  assign bus.csel       = r_csel;
endmodule

// File: tb/tb_conv5x5_ctrl.sv
// Directed bench: a 64x64 instance for first-pixel and mid-job reset sequences,
// and a 16x8 instance for complete jobs, last-pixel windows and back-to-back starts.
module tb_conv5x5_ctrl;
  localparam int B_IW    = 16;
  localparam int B_IH    = 8;
  localparam int B_NPIX  = B_IW * B_IH;
  localparam int B_NPOOL = B_NPIX / 4;
  localparam int B_BUSY  = B_NPIX * 26 + B_NPOOL * 5;
  localparam int B_LIMIT = 6000;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  conv5x5_ctrl_if #(.AW(12), .TW(5)) if_a ();
  conv5x5_ctrl_if #(.AW(7),  .TW(5)) if_b ();

  conv5x5_ctrl #(.IW(64), .IH(64), .KSZ(5)) u_dut_a (.clk(clk), .reset(rst_a), .bus(if_a));
  conv5x5_ctrl #(.IW(B_IW), .IH(B_IH), .KSZ(5)) u_dut_b (.clk(clk), .reset(rst_b), .bus(if_b));

  // -1 marks a padded tap
  int tbl_a00[25] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1,
                      0, 1, 2, -1, -1, 64, 65, 66, -1, -1, 128, 129, 130};
  int tbl_blast[25] = '{93, 94, 95, -1, -1, 109, 110, 111, -1, -1, 125, 126, 127,
                        -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
  int tbl_p0[4]  = '{0, 1, 16, 17};
  int tbl_pl[4]  = '{110, 111, 126, 127};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_busy"},       if_a.busy,       0);
    chk({tag, "_iaddr"},      if_a.iaddr,      0);
    chk({tag, "_tap_vld"},    if_a.tap_vld,    0);
    chk({tag, "_tap_pad"},    if_a.tap_pad,    0);
    chk({tag, "_tap_idx"},    if_a.tap_idx,    0);
    chk({tag, "_tap_first"},  if_a.tap_first,  0);
    chk({tag, "_tap_last"},   if_a.tap_last,   0);
    chk({tag, "_crd"},        if_a.crd,        0);
    chk({tag, "_caddr_rd"},   if_a.caddr_rd,   0);
    chk({tag, "_pool_vld"},   if_a.pool_vld,   0);
    chk({tag, "_pool_first"}, if_a.pool_first, 0);
    chk({tag, "_cwr"},        if_a.cwr,        0);
    chk({tag, "_caddr_wr"},   if_a.caddr_wr,   0);
    chk({tag, "_csel"},       if_a.csel,       0);
  endtask

  // Entered on the first CONV cycle of pixel (0,0); leaves on its L0WR cycle.
  task automatic check_a_pixel00(input string tag);
    for (int t = 0; t < 25; t++) begin
      chk($sformatf("%s_t%0d_vld", tag, t), if_a.tap_vld, 1);
      chk($sformatf("%s_t%0d_idx", tag, t), if_a.tap_idx, t);
      if (tbl_a00[t] < 0) begin
        chk($sformatf("%s_t%0d_pad", tag, t),   if_a.tap_pad, 1);
        chk($sformatf("%s_t%0d_iaddr", tag, t), if_a.iaddr,   0);
      end else begin
        chk($sformatf("%s_t%0d_pad", tag, t),   if_a.tap_pad, 0);
        chk($sformatf("%s_t%0d_iaddr", tag, t), if_a.iaddr,   tbl_a00[t]);
      end
      if (t == 0) begin
        chk({tag, "_busy_first"}, if_a.busy,      1);
        chk({tag, "_tap_first"},  if_a.tap_first, 1);
      end
      if (t == 24) chk({tag, "_tap_last"}, if_a.tap_last, 1);
      @(negedge clk);
    end
    chk({tag, "_l0wr_cwr"},   if_a.cwr,      1);
    chk({tag, "_l0wr_csel"},  if_a.csel,     0);
    chk({tag, "_l0wr_addr"},  if_a.caddr_wr, 0);
    chk({tag, "_l0wr_tvld"},  if_a.tap_vld,  0);
    chk({tag, "_l0wr_busy"},  if_a.busy,     1);
  endtask

  // Entered on the first CONV cycle of a job; returns on the DONE cycle.
  task automatic monitor_b(input string job);
    int  busy_n = 0, l0_n = 0, l1_n = 0, pix = 0, t = 0, j = 0;
    int  e_scan = 0, e_pool = 0, e_excl = 0, e_idle = 0, e_wr = 0;
    int  r, c, y, x, ea, p, q, pr, pc, a;
    bit  ep;
    bit  done = 1'b0;
    bit  l0_seen[B_NPIX];
    bit  l1_seen[B_NPOOL];
    for (int cyc = 0; cyc < B_LIMIT && !done; cyc++) begin
      if (!if_b.busy) begin
        done = 1'b1;
      end else begin
        busy_n++;
        if (if_b.cwr && if_b.crd) e_excl++;
        if (if_b.tap_vld && if_b.pool_vld) e_excl++;
        if (if_b.tap_vld) begin
          r  = pix / B_IW;
          c  = pix % B_IW;
          y  = r + t / 5 - 2;
          x  = c + t % 5 - 2;
          ep = (y < 0 || y >= B_IH || x < 0 || x >= B_IW);
          ea = ep ? 0 : y * B_IW + x;
          if (if_b.iaddr !== 7'(ea) || if_b.tap_pad !== ep || if_b.tap_idx !== 5'(t) ||
              if_b.tap_first !== (t == 0) || if_b.tap_last !== (t == 24)) e_scan++;
          if (pix == B_NPIX - 1) begin
            if (tbl_blast[t] < 0) chk($sformatf("%s_last_t%0d_pad", job, t), if_b.tap_pad, 1);
            else chk($sformatf("%s_last_t%0d_iaddr", job, t), if_b.iaddr, tbl_blast[t]);
          end
          t++;
          if (t == 25) begin
            t = 0;
            pix++;
          end
        end else if (if_b.iaddr !== 0 || if_b.tap_pad || if_b.tap_idx !== 0 ||
                     if_b.tap_first || if_b.tap_last) begin
          e_idle++;
        end
        if (if_b.crd) begin
          p  = j / 4;
          q  = j % 4;
          pr = p / (B_IW / 2);
          pc = p % (B_IW / 2);
          ea = (2 * pr + q / 2) * B_IW + 2 * pc + q % 2;
          if (if_b.caddr_rd !== 7'(ea) || if_b.pool_vld !== 1'b1 ||
              if_b.pool_first !== (q == 0) || if_b.csel !== 1'b0) e_pool++;
          if (j < 4) chk($sformatf("%s_p0_rd%0d", job, j), if_b.caddr_rd, tbl_p0[j]);
          if (j == 0) chk({job, "_p0_first"}, if_b.pool_first, 1);
          if (j >= B_NPIX - 4) chk($sformatf("%s_pl_rd%0d", job, j), if_b.caddr_rd, tbl_pl[j - (B_NPIX - 4)]);
          j++;
        end else if (if_b.caddr_rd !== 0 || if_b.pool_vld || if_b.pool_first) begin
          e_idle++;
        end
        if (if_b.cwr) begin
          a = int'(if_b.caddr_wr);
          if (!if_b.csel) begin
            if (l0_seen[a] || a != l0_n || pix != l0_n + 1) e_wr++;
            l0_seen[a] = 1'b1;
            if (l0_n == 0) chk({job, "_l0_first_addr"}, if_b.caddr_wr, 0);
            if (l0_n == B_NPIX - 1) chk({job, "_l0_last_addr"}, if_b.caddr_wr, B_NPIX - 1);
            l0_n++;
          end else begin
            if (a >= B_NPOOL || l1_seen[a % B_NPOOL] || j != 4 * (l1_n + 1)) e_wr++;
            l1_seen[a % B_NPOOL] = 1'b1;
            if (l1_n == 0) chk({job, "_l1_first_addr"}, if_b.caddr_wr, 0);
            if (l1_n == B_NPOOL - 1) chk({job, "_l1_last_addr"}, if_b.caddr_wr, B_NPOOL - 1);
            l1_n++;
          end
        end
        @(negedge clk);
      end
    end
    chk({job, "_finished"},   done,   1);
    chk({job, "_busy_cyc"},   busy_n, B_BUSY);
    chk({job, "_l0_writes"},  l0_n,   B_NPIX);
    chk({job, "_l1_writes"},  l1_n,   B_NPOOL);
    chk({job, "_pixels"},     pix,    B_NPIX);
    chk({job, "_pool_reads"}, j,      B_NPIX);
    chk({job, "_scan_err"},   e_scan, 0);
    chk({job, "_pool_err"},   e_pool, 0);
    chk({job, "_excl_err"},   e_excl, 0);
    chk({job, "_idle_err"},   e_idle, 0);
    chk({job, "_wr_err"},     e_wr,   0);
  endtask

  initial begin
    bit found;
    int gap;
    rst_a      = 1'b1;
    rst_b      = 1'b1;
    if_a.ready = 1'b0;
    if_b.ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_a("rst");
    chk("rst_b_busy", if_b.busy, 0);
    chk("rst_b_cwr",  if_b.cwr,  0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    chk_zero_a("idle");

    // First pixel of a 64x64 job
    if_a.ready = 1'b1;
    @(negedge clk);
    if_a.ready = 1'b0;
    check_a_pixel00("s1");

    // Run to pixel (10,5), reset at its centre tap, then restart
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      if (if_a.cwr && if_a.caddr_wr == 12'd644) found = 1'b1;
      else @(negedge clk);
    end
    chk("s5_reach_644", found, 1);
    repeat (13) @(negedge clk);
    chk("s5_t12_idx",   if_a.tap_idx, 12);
    chk("s5_t12_iaddr", if_a.iaddr,   645);
    chk("s5_t12_pad",   if_a.tap_pad, 0);
    rst_a = 1'b1;
    @(negedge clk);
    chk_zero_a("s5_rst");
    rst_a = 1'b0;
    @(negedge clk);
    chk("s5_idle_busy", if_a.busy, 0);
    if_a.ready = 1'b1;
    @(negedge clk);
    if_a.ready = 1'b0;
    check_a_pixel00("s5_restart");
    rst_a = 1'b1;

    // Complete 16x8 job started by a one-cycle ready pulse
    if_b.ready = 1'b1;
    @(negedge clk);
    if_b.ready = 1'b0;
    monitor_b("s4");
    chk("s4_done_busy", if_b.busy, 0);
    chk("s4_done_cwr",  if_b.cwr,  0);
    repeat (2) @(negedge clk);
    chk("s4_idle_busy", if_b.busy, 0);

    // ready held high across two back-to-back jobs
    if_b.ready = 1'b1;
    @(negedge clk);
    monitor_b("s6j1");
    gap = 0;
    for (int i = 0; i < 8 && !if_b.busy; i++) begin
      gap++;
      @(negedge clk);
    end
    chk("s6_gap",        gap,            2);
    chk("s6_restart",    if_b.busy,      1);
    chk("s6_tap_first",  if_b.tap_first, 1);
    chk("s6_tap_pad",    if_b.tap_pad,   1);
    monitor_b("s6j2");
    if_b.ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("s6_end_busy", if_b.busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/conv5x5_ctrl.md
Name: conv5x5_ctrl

Overview:
Sequencer for the CONV5x5 accelerator datapath. It scans a 64x64 image with a 5x5 zero-padded window and generates image addresses and MAC tap strobes. It then issues the layer-0 result writes, runs the 2x2 max-pool read/write pass from layer-0 into layer-1 memory, and drives the busy/ready host handshake. It owns all address and strobe generation; the arithmetic datapath (MAC, bias, ReLU, max compare) is external and follows its strobes.

Parameters:
IW, 64, image width in pixels (power of 2)
IH, 64, image height in pixels (power of 2, even)
KSZ, 5, kernel size (odd); pad PAD = (KSZ-1)/2
Address widths below assume defaults: AW = log2(IW*IH) = 12.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
ready  in  1  host start request, sampled only in IDLE
busy  out  1  high while the job is running
iaddr  out  12  image memory address
tap_vld  out  1  MAC accumulate strobe; idata is valid this cycle
tap_pad  out  1  current tap lies outside the image; datapath uses 0
tap_idx  out  5  kernel tap index 0..KSZ*KSZ-1
tap_first  out  1  tap_idx==0; datapath clears its accumulator
tap_last  out  1  tap_idx==KSZ*KSZ-1
crd  out  1  result memory read strobe
caddr_rd  out  12  result memory read address
pool_vld  out  1  cdata_rd is valid this cycle; datapath does max compare
pool_first  out  1  first of 4 pool reads; datapath loads instead of compares
cwr  out  1  result memory write strobe
caddr_wr  out  12  result memory write address
csel  out  1  0 = layer-0 memory, 1 = layer-1 memory

Behaviour:
- Reset and clocking: one clock domain. While reset=1, at the next edge the state goes to IDLE and every output is 0.
- Registered outputs: all outputs are registered. No output depends combinationally on ready.
- States: IDLE, CONV, L0WR, POOL, L1WR, DONE.
- IDLE: busy=0. If ready=1 at an edge, enter CONV with pixel (r,c)=(0,0), tap 0, and busy=1 in the same cycle.
- CONV: one tap per cycle, t = 0..24, ky = t/5, kx = t%5.
  - Source pixel: y = r+ky-2, x = c+kx-2.
  - In range: iaddr = y*IW+x and tap_pad=0.
  - Out of range: iaddr = 0 and tap_pad=1.
  - tap_vld=1 in every CONV cycle. After t=24, go to L0WR.
- L0WR: one cycle, cwr=1, csel=0, caddr_wr = r*IW+c.
  - The datapath presents the final sum on cdata_wr this cycle.
  - Advance (r,c) row-major: if more pixels remain, return to CONV; after (63,63), go to POOL with (pr,pc)=(0,0).
- POOL: 4 cycles, crd=1, csel=0, pool_vld=1.
  - Read order: (dy,dx) = (0,0),(0,1),(1,0),(1,1); caddr_rd = (2pr+dy)*IW + 2pc+dx.
  - pool_first=1 on the first read only. Then go to L1WR.
- L1WR: one cycle, cwr=1, csel=1, caddr_wr = pr*(IW/2)+pc.
  - Advance (pr,pc) row-major over 32x32: return to POOL, or after (31,31) go to DONE.
- DONE: busy=0 for one cycle, then IDLE.
- Timing per pixel: 26 cycles per layer-0 pixel, 5 cycles per layer-1 pixel. busy is high for exactly 4096*26 + 1024*5 = 111616 cycles.
- Exclusivity: cwr and crd are never both 1. tap_vld and pool_vld are never both 1.
- Write coverage: every layer-0 address 0..4095 and every layer-1 address 0..1023 is written exactly once per job.
- Idle strobes: outside CONV, tap_* = 0 and iaddr holds 0. crd=0 and caddr_rd=0 outside POOL.
- ready handling: ready is ignored while busy=1 and in DONE. If ready is still high in IDLE, a new job starts.
- Reset mid-job: abort with no further cwr/crd pulses. The next job restarts at pixel (0,0).

Test Plan:
1. Reset, then ready=1 -> busy=1 on the first CONV cycle. Pixel (0,0):
   - Taps 0-11, 15, 16, 20, 21 give tap_pad=1.
   - Taps 12,13,14,17,18,19,22,23,24 give iaddr 0,1,2,64,65,66,128,129,130.
   - Cycle 26: cwr=1, csel=0, caddr_wr=0.
2. Pixel (63,63):
   - Taps 0,1,2,5,6,7,10,11,12 give iaddr 3965,3966,3967,4029,4030,4031,4093,4094,4095; all other taps have tap_pad=1.
   - Then caddr_wr=4095 with csel=0.
3. Pool pixel (0,0): caddr_rd 0,1,64,65 with pool_first on the first read, then cwr with csel=1, caddr_wr=0. Pool pixel (31,31): caddr_rd 4030,4031,4094,4095, then caddr_wr=1023.
4. Full job:
   - busy is high for exactly 111616 cycles.
   - 4096 writes with csel=0 and 1024 writes with csel=1, each address written once.
   - cwr&crd never asserted.
5. Assert reset during CONV pixel (10,5) -> next cycle all outputs 0. A new ready restarts at pixel (0,0) with iaddr sequence identical to scenario 1.
6. ready held high for the whole job -> no disturbance while busy. DONE gives 1 cycle of busy=0, then a second job starts from IDLE.
